// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: word width, NOP encoding,
// load/run FSM state encoding and the per-word parity helper.
package inst_mem_pkg;

    localparam int          IMEM_WORD_LEN = 32;
    localparam logic [31:0] IMEM_NOP      = 32'h0000_0013;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Even parity: stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [IMEM_WORD_LEN-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles little-endian load bytes into instruction words; a flush emits a
// partially filled word with the unfilled upper bytes forced to zero.
module imem_byte_packer
    import inst_mem_pkg::*;
#(
    parameter int WORD_LEN = IMEM_WORD_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                byte_en,
    input  logic [7:0]          byte_data,
    input  logic                flush,
    output logic [WORD_LEN-1:0] word,
    output logic                word_we
);
    localparam int NB = WORD_LEN / 8;
    localparam int CW = $clog2(NB) + 1;

    logic [CW-1:0]        bcnt_r;
    logic [CW-1:0]        cnt_next_s;
    logic [NB-1:0][7:0]   lanes_r;
    logic [NB-1:0][7:0]   word_s;
    logic                 full_s;

    // Merge the current byte into the held lanes; lanes at or above the fill level read as zero
    always_comb begin
        cnt_next_s = bcnt_r + {{(CW-1){1'b0}}, byte_en};
        for (int i = 0; i < NB; i++) begin
            if (CW'(i) < bcnt_r) begin
                word_s[i] = lanes_r[i];
            end else if ((CW'(i) == bcnt_r) && byte_en) begin
                word_s[i] = byte_data;
            end else begin
                word_s[i] = 8'h00;
            end
        end
        full_s  = (cnt_next_s == CW'(NB));
        word_we = !clr && (full_s || (flush && (cnt_next_s != {CW{1'b0}})));
        word    = word_s;
    end

    // Lane storage and byte counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_r  <= {CW{1'b0}};
            lanes_r <= {(NB*8){1'b0}};
        end else if (clr || flush || full_s) begin
            bcnt_r <= {CW{1'b0}};
        end else if (byte_en) begin
            lanes_r[bcnt_r[CW-2:0]] <= byte_data;
            bcnt_r                  <= cnt_next_s;
        end else begin
            bcnt_r <= bcnt_r;
        end
    end

endmodule

// File: rtl/inst_mem.sv
// Loadable instruction memory: byte-stream program load, then single-cycle fetch.
// Optional per-word parity checking is enabled by defining IMEM_PARITY_EN.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int WORD_LEN = IMEM_WORD_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORD_LEN-1:0] req_addr,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_inst,
    input  logic                ld_start,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [7:0]          ld_data,
    input  logic                ld_done,
    output logic                loaded
`ifdef IMEM_PARITY_EN
    ,
    output logic                par_err
`endif
);
    localparam int            AW        = $clog2(DEPTH);
    localparam int            PW        = AW + 1;
    localparam logic [PW-1:0] WPTR_FULL = PW'(DEPTH);

    logic [1:0]          state_r;
    logic [PW-1:0]       wptr_r;
    logic [WORD_LEN-1:0] mem_r [DEPTH];
    logic                resp_valid_r;
    logic [WORD_LEN-1:0] resp_inst_r;

    logic                in_load_s;
    logic                in_run_s;
    logic                has_room_s;
    logic                req_fire_s;
    logic                byte_en_s;
    logic                flush_s;
    logic                pk_we_s;
    logic                mem_we_s;
    logic                hit_s;
    logic [AW-1:0]       rd_idx_s;
    logic [WORD_LEN-1:0] pk_word_s;
    logic [WORD_LEN-1:0] rd_word_s;

    // Handshake decode and read path; words at or beyond wptr read as NOP
    always_comb begin
        in_load_s  = (state_r == ST_LOAD);
        in_run_s   = (state_r == ST_RUN);
        has_room_s = (wptr_r < WPTR_FULL);
        req_fire_s = req_valid && in_run_s && !ld_start;
        byte_en_s  = ld_valid && in_load_s && has_room_s && !ld_start;
        flush_s    = ld_done && in_load_s && !ld_start;
        mem_we_s   = pk_we_s && in_load_s && has_room_s;
        rd_idx_s   = req_addr[AW-1:0];
        hit_s      = ({{(WORD_LEN-PW){1'b0}}, wptr_r} > req_addr);
        rd_word_s  = mem_r[rd_idx_s];
    end

    assign req_ready  = in_run_s && !ld_start;
    assign ld_ready   = in_load_s && has_room_s;
    assign loaded     = in_run_s;
    assign resp_valid = resp_valid_r;
    assign resp_inst  = resp_inst_r;

    imem_byte_packer #(
        .WORD_LEN (WORD_LEN)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ld_start),
        .byte_en   (byte_en_s),
        .byte_data (ld_data),
        .flush     (flush_s),
        .word      (pk_word_s),
        .word_we   (pk_we_s)
    );

    // Load/run sequencing; ld_start from any state (re)starts a load from word 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wptr_r  <= {PW{1'b0}};
        end else if (ld_start) begin
            state_r <= ST_LOAD;
            wptr_r  <= {PW{1'b0}};
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (mem_we_s) begin
                        wptr_r <= wptr_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                    if (ld_done) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_IDLE, ST_RUN: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wptr_r  <= {PW{1'b0}};
                end
            endcase
        end
    end

    // Instruction storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wptr_r[AW-1:0]] <= pk_word_s;
        end
    end

    // Fetch response, captured at acceptance so a following reload cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_inst_r  <= {WORD_LEN{1'b0}};
        end else begin
            resp_valid_r <= req_fire_s;
            if (req_fire_s) begin
                resp_inst_r <= hit_s ? rd_word_s : IMEM_NOP;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem_r [DEPTH];
    logic par_err_r;

    // Parity bit stored alongside each word
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            par_mem_r[wptr_r[AW-1:0]] <= even_parity(pk_word_s);
        end
    end

    // Sticky parity error, cleared only by reset or a new load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_r <= 1'b0;
        end else if (ld_start) begin
            par_err_r <= 1'b0;
        end else if (req_fire_s && hit_s && (par_mem_r[rd_idx_s] != even_parity(rd_word_s))) begin
            par_err_r <= 1'b1;
        end
    end

    assign par_err = par_err_r;
`endif

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: behavioural image model plus directed literal checks.
module tb_inst_mem;
    import inst_mem_pkg::*;

    localparam int DEPTH = 16;
    localparam int WL    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [WL-1:0] req_addr;
    logic          resp_valid;
    logic [WL-1:0] resp_inst;
    logic          ld_start;
    logic          ld_valid;
    logic          ld_ready;
    logic [7:0]    ld_data;
    logic          ld_done;
    logic          loaded;
`ifdef IMEM_PARITY_EN
    logic          par_err;
`endif

    inst_mem #(.DEPTH(DEPTH), .WORD_LEN(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_done    (ld_done),
        .loaded     (loaded)
`ifdef IMEM_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, bytes of the load in progress, committed image
    int          m_state = 0;   // 0 idle, 1 load, 2 run
    logic [7:0]  m_q[$];
    logic [31:0] m_words[DEPTH];
    int          m_nwords = 0;
    logic        e_valid = 1'b0;
    logic [31:0] e_inst = 32'h0;
    logic        e_par = 1'b0;
    int          m_bad_addr = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_q.delete();
            m_nwords = 0;
            e_valid = 1'b0;
            e_inst = 32'h0;
            e_par = 1'b0;
            m_bad_addr = -1;
        end else begin
            e_valid = 1'b0;
            if (m_state == 2 && !ld_start && req_valid) begin
                e_valid = 1'b1;
                if (req_addr < 32'(m_nwords)) begin
                    e_inst = m_words[int'(req_addr)];
                    if (m_bad_addr >= 0 && req_addr == 32'(m_bad_addr)) e_par = 1'b1;
                end else begin
                    e_inst = 32'h0000_0013;
                end
            end
            if (ld_start) begin
                m_state = 1;
                m_q.delete();
                e_par = 1'b0;
                m_bad_addr = -1;
            end else if (m_state == 1) begin
                if (ld_valid && m_q.size() < 4 * DEPTH) m_q.push_back(ld_data);
                if (ld_done) begin
                    m_nwords = (m_q.size() + 3) / 4;
                    for (int w = 0; w < m_nwords; w++) begin
                        m_words[w] = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (4 * w + b < m_q.size()) m_words[w][8*b +: 8] = m_q[4 * w + b];
                    end
                    m_state = 2;
                end
            end
        end
    end

    // Compare process: every output against the model, mid-cycle
    always @(negedge clk) begin
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, e_valid});
        chk("resp_inst", resp_inst, e_inst);
        chk("loaded", {31'h0, loaded}, {31'h0, m_state == 2});
        chk("req_ready", {31'h0, req_ready}, {31'h0, (m_state == 2) && !ld_start});
        chk("ld_ready", {31'h0, ld_ready}, {31'h0, (m_state == 1) && (m_q.size() < 4 * DEPTH)});
`ifdef IMEM_PARITY_EN
        chk("par_err", {31'h0, par_err}, {31'h0, e_par});
`endif
    end

    logic [7:0] img[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_img(input bit merge_done);
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
        foreach (img[i]) begin
            if ($urandom_range(0, 3) == 0) cyc();
            ld_valid = 1'b1;
            ld_data  = img[i];
            if (merge_done && i == img.size() - 1) ld_done = 1'b1;
            cyc();
            ld_valid = 1'b0;
        end
        if (!(merge_done && img.size() > 0)) begin
            ld_done = 1'b1;
            cyc();
        end
        ld_done = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        cyc();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b1; req_valid = 1'b0; req_addr = 32'h0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_data = 8'h0; ld_done = 1'b0;
        #1 rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_inst", resp_inst, 32'h0);
        chk("rst_loaded", {31'h0, loaded}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Four bytes, one word
        img = '{8'h31, 8'h32, 8'h33, 8'h34};
        load_img(1'b0);
        fetch(32'd0);
        chk("w4_valid", {31'h0, resp_valid}, 32'h1);
        chk("w4_inst", resp_inst, 32'h3433_3231);

        // Six bytes: partial second word zero-padded, third word is NOP
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_img(1'b1);
        fetch(32'd1);
        chk("b6_addr1", resp_inst, 32'h0000_0605);
        fetch(32'd2);
        chk("b6_addr2", resp_inst, 32'h0000_0013);
        fetch(32'd0);
        chk("b6_addr0", resp_inst, 32'h0403_0201);

        // Eight words, back-to-back fetches
        img.delete();
        for (int i = 0; i < 32; i++) img.push_back(8'(i * 7 + 3));
        load_img(1'b0);
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i);
            cyc();
            w = {8'((4*i+3)*7+3), 8'((4*i+2)*7+3), 8'((4*i+1)*7+3), 8'((4*i)*7+3)};
            chk("b2b_valid", {31'h0, resp_valid}, 32'h1);
            chk("b2b_inst", resp_inst, w);
        end
        req_valid = 1'b0;
        cyc();
        chk("b2b_idle", {31'h0, resp_valid}, 32'h0);

        // Request then reload on the following cycle
        img = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
        load_img(1'b0);
        req_valid = 1'b1; req_addr = 32'd0;
        cyc();
        req_addr = 32'd1; ld_start = 1'b1;
        #1;
        chk("rl_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rl_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("rl_resp_inst", resp_inst, 32'hddcc_bbaa);
        cyc();
        ld_start = 1'b0; req_valid = 1'b0;
        chk("rl_loaded", {31'h0, loaded}, 32'h0);
        chk("rl_refused", {31'h0, resp_valid}, 32'h0);
        ld_done = 1'b1;
        cyc();
        ld_done = 1'b0;
        fetch(32'd0);
        chk("rl_empty_nop", resp_inst, 32'h0000_0013);

        // Overflow: bytes past DEPTH words dropped, done still completes
        img.delete();
        for (int i = 0; i < 4 * DEPTH + 5; i++) img.push_back(8'(i));
        load_img(1'b1);
        fetch(32'(DEPTH - 1));
        chk("ovf_last", resp_inst, {8'(4*DEPTH-1), 8'(4*DEPTH-2), 8'(4*DEPTH-3), 8'(4*DEPTH-4)});
        fetch(32'(DEPTH));
        chk("ovf_beyond", resp_inst, 32'h0000_0013);
        fetch(32'hffff_fff0);
        chk("ovf_huge", resp_inst, 32'h0000_0013);

        // Reset in the middle of a load
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h77; cyc(); ld_data = 8'h88; cyc(); ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_loaded", {31'h0, loaded}, 32'h0);
        chk("mr_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("mr_resp_inst", resp_inst, 32'h0);
        cyc();
        rst_n = 1'b1;
        fetch(32'd0);
        chk("mr_no_resp", {31'h0, resp_valid}, 32'h0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_img(1'b0);
        fetch(32'd0);
        chk("mr_reload", resp_inst, 32'h4433_2211);

        // Randomized loads (with occasional restarts) and fetch bursts
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                ld_start = 1'b1; cyc(); ld_start = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    ld_valid = 1'b1; ld_data = 8'($urandom); cyc();
                end
                ld_valid = 1'b0;
            end
            img.delete();
            for (int i = 0; i < int'($urandom_range(0, 4 * DEPTH + 8)); i++) img.push_back(8'($urandom));
            load_img(1'($urandom_range(0, 1)));
            for (int c = 0; c < 30; c++) begin
                req_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) req_addr = 32'hffff_fff0 | 32'($urandom_range(0, 15));
                else req_addr = 32'($urandom_range(0, DEPTH + 3));
                ld_start = (c == 29) && ($urandom_range(0, 2) == 0);
                cyc();
            end
            req_valid = 1'b0;
            ld_start  = 1'b0;
            cyc();
        end

`ifdef IMEM_PARITY_EN
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'(i + 8'h40));
        load_img(1'b0);
        dut.par_mem_r[3] = ~dut.par_mem_r[3];
        m_bad_addr = 3;
        fetch(32'd2);
        chk("par_clean", {31'h0, par_err}, 32'h0);
        fetch(32'd3);
        chk("par_set", {31'h0, par_err}, 32'h1);
        cyc(); cyc();
        chk("par_held", {31'h0, par_err}, 32'h1);
        ld_start = 1'b1; cyc(); ld_start = 1'b0;
        chk("par_clear", {31'h0, par_err}, 32'h0);
        ld_done = 1'b1; cyc(); ld_done = 1'b0;
`endif

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
